uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
//  UART serial receiver, 8-N-1, LSB first; companion to the UART transmitter.
//  Oversamples the asynchronous RXD line with the system clock and samples each bit at mid-bit.
//  Presents each received byte in a one-entry holding register with a valid/ack handshake.
//  Drives RTS low while that register is full, so the remote transmitter pauses.
//
// PARAMETERS
//  BITCLKS  868  system clocks per bit (100 MHz / 115200 bps); minimum 4
//  TMR_LEN  14   bit-timer width; must satisfy 2^TMR_LEN > BITCLKS
//
// PORTS
//  clk    in   1  system clock
//  rst    in   1  synchronous reset, active high
//  rxd    in   1  RX serial line (asynchronous; idle = 1)
//  data   out  8  received byte; stable while valid = 1
//  valid  out  1  holding register full
//  ack    in   1  consumer takes data; ignored when valid = 0
//  ferr   out  1  one-cycle pulse: framing error (stop bit read as 0)
//  ovf    out  1  one-cycle pulse: overrun (byte completed while register full, no ack)
//  rts    out  1  RTS out (1 = this side accepts); equals ~valid
//
// BEHAVIOUR
//  Reset (one-cycle rst = 1 is sufficient):
//  - outputs: data = 0, valid = 0, ferr = 0, ovf = 0, rts = 1
//  - internal: synchronizer flops = 1, FSM = IDLE, timer = 0
//  - mid-frame reset abandons the frame; no valid, ferr or ovf results from it.
//  Synchronizer: rxd passes through 2 flops (rxs); all decisions use rxs only (2-cycle input latency).
//  Bit timer: tmr loads, then decrements once per cycle; the sample point is tmr == 0.
//  FSM states:
//  - IDLE:  rxs == 0 -> tmr <= BITCLKS/2 - 1 (integer division), go START.
//  - START: at tmr == 0, sample rxs.
//           rxs == 1 -> false start: go IDLE, no flags.
//           rxs == 0 -> tmr <= BITCLKS - 1, idx <= 0, go DATA.
//  - DATA:  at tmr == 0, shift rxs in at bit idx (LSB first), idx <= idx + 1, tmr <= BITCLKS - 1.
//           After the 8th bit, go STOP.
//  - STOP:  at tmr == 0, sample rxs.
//           rxs == 1 -> deliver the byte (see Delivery), go IDLE.
//           rxs == 0 -> ferr = 1 for one cycle, byte discarded, go BREAK.
//  - BREAK: stay until rxs == 1, then go IDLE. A held-low line (break) yields exactly one ferr.
//  Sample timing relative to the IDLE->START edge (cycle 0):
//  - start bit sampled at cycle BITCLKS/2
//  - data bit k (k = 0..7) sampled at BITCLKS/2 + (k+1)*BITCLKS
//  - stop bit sampled at BITCLKS/2 + 9*BITCLKS
//  Delivery, on the stop-sample cycle:
//  - valid == 0, or valid == 1 and ack == 1: data <= byte, valid <= 1 (visible next cycle).
//  - valid == 1 and ack == 0: byte dropped, data unchanged, ovf = 1 for one cycle.
//  Handshake:
//  - ack with valid == 1 and no delivery that cycle -> valid <= 0 next cycle.
//  - simultaneous ack and delivery -> new data loaded, valid stays 1, no ovf.
//  - ack while valid == 0 has no effect.
//  Timing tolerance: next frame accepted immediately after the stop sample.
//  Back-to-back frames at up to +/-4% baud mismatch are received correctly.
//  Flags: ferr and ovf are registered, never both high in the same cycle, and cleared the following cycle.
//
// TESTING (BITCLKS = 16 unless noted)
//  1. Reset: after rst, rxd = 1 -> data = 0, valid = 0, rts = 1, ferr = ovf = 0.
//     Hold 100 cycles -> no change.
//  2. Send 0xA5, ideal timing -> valid rises 2 + 8 + 9*16 (+1) cycles after start edge; data = 0xA5, rts = 0.
//     ack -> valid = 0, rts = 1.
//  3. Glitch: rxd low 4 cycles, then high -> no valid, no ferr; a following frame 0x3C is received correctly.
//  4. Framing: frame 0x3C with stop = 0, line then held low 40 cycles, then high -> exactly one ferr pulse, valid = 0.
//     Next frame 0x81 -> data = 0x81.
//  5. Overrun: frames 0x11 then 0x22, no ack -> data = 0x11, one ovf pulse.
//     Repeat, with ack asserted on the 0x22 stop-sample cycle -> data = 0x22, valid stays 1, no ovf.
//  6. Reset mid-frame after bit 3 of 0xFF, then line idle -> no valid/ferr.
//     Next frame 0x5A at BITCLKS = 17 and at a +3% rate -> data = 0x5A.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle: received byte with valid/ack, status pulses and RTS.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic       ferr;
  logic       ovf;
  logic       rts;

  modport master (output data, valid, ferr, ovf, rts, input ack);
  modport slave  (input data, valid, ferr, ovf, rts, output ack);
endinterface

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: oversamples rxd, samples each bit at mid-bit, holds one byte
// behind a valid/ack handshake and drives RTS low while that byte is pending.
module uart_rx #(
  parameter int unsigned BITCLKS = 868,
  parameter int unsigned TMR_LEN = 14
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rxd,
  uart_rx_if.master bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  localparam logic [TMR_LEN-1:0] TmrHalf = TMR_LEN'(BITCLKS / 2 - 1);
  localparam logic [TMR_LEN-1:0] TmrFull = TMR_LEN'(BITCLKS - 1);

  state_e             state_q;
  logic               rxs1_q;
  logic               rxs_q;
  logic [TMR_LEN-1:0] tmr_q;
  logic [2:0]         idx_q;
  logic [7:0]         shift_q;
  logic [7:0]         data_q;
  logic               valid_q;
  logic               ferr_q;
  logic               ovf_q;
  logic               tick;

  assign tick = (tmr_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rxs1_q  <= 1'b1;
      rxs_q   <= 1'b1;
      tmr_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rxs1_q <= rxd;
      rxs_q  <= rxs1_q;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
      if (!tick) tmr_q <= tmr_q - 1'b1;
      // A delivery in the stop state below overrides this release.
      if (valid_q && bus.ack) valid_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            tmr_q   <= TmrHalf;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            if (rxs_q) begin
              state_q <= StIdle;
            end else begin
              tmr_q   <= TmrFull;
              idx_q   <= '0;
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (tick) begin
            shift_q <= {rxs_q, shift_q[7:1]};
            idx_q   <= idx_q + 1'b1;
            tmr_q   <= TmrFull;
            if (idx_q == 3'd7) state_q <= StStop;
          end
        end
        StStop: begin
          if (tick) begin
            if (rxs_q) begin
              if (valid_q && !bus.ack) begin
                ovf_q <= 1'b1;
              end else begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end
              state_q <= StIdle;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= StBreak;
            end
          end
        end
        StBreak: begin
          if (rxs_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.ferr  = ferr_q;
  assign bus.ovf   = ovf_q;
  assign bus.rts   = ~valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16-clock bit instance for most steps, 17-clock instance for odd
// bit length.
`timescale 1ns/1ps
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;

  uart_rx_if bus_a ();
  uart_rx_if bus_b ();

  uart_rx #(.BITCLKS(16), .TMR_LEN(14)) dut_a (.clk(clk), .rst(rst), .rxd(rxd_a), .bus(bus_a));
  uart_rx #(.BITCLKS(17), .TMR_LEN(14)) dut_b (.clk(clk), .rst(rst), .rxd(rxd_b), .bus(bus_b));

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  int   ferr_cnt = 0;
  int   ovf_cnt = 0;
  int   both_cnt = 0;
  logic valid_prev = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus_a.valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
    valid_prev = bus_a.valid;
    if (bus_a.ferr === 1'b1) ferr_cnt++;
    if (bus_a.ovf === 1'b1) ovf_cnt++;
    if (bus_a.ferr === 1'b1 && bus_a.ovf === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input bit to_b);
    if (to_b) rxd_b = v;
    else rxd_a = v;
  endtask

  // Line is left at the stop-bit level when the task returns.
  task automatic send(input logic [7:0] b, input logic stopb, input real bit_ns, input bit to_b);
    drive(1'b0, to_b);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      drive(b[i], to_b);
      #(bit_ns);
    end
    drive(stopb, to_b);
    #(bit_ns);
  endtask

  task automatic ack_a();
    align();
    bus_a.ack = 1'b1;
    align();
    bus_a.ack = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0, fall_cyc;
    bus_a.ack = 1'b0;
    bus_b.ack = 1'b0;
    rst = 1'b1;
    repeat (3) align();
    rst = 1'b0;
    align();

    // 1. Reset state, then idle line for 100 cycles
    check("rst_data", bus_a.data, 8'h00);
    check("rst_valid", bus_a.valid, 1'b0);
    check("rst_rts", bus_a.rts, 1'b1);
    check("rst_ferr", bus_a.ferr, 1'b0);
    check("rst_ovf", bus_a.ovf, 1'b0);
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    repeat (100) align();
    check("idle_valid", bus_a.valid, 1'b0);
    check("idle_data", bus_a.data, 8'h00);
    check("idle_rts", bus_a.rts, 1'b1);
    check("idle_flags", (ferr_cnt - f0) + (ovf_cnt - o0), 0);

    // 2. 0xA5, valid latency from the falling start edge
    align();
    fall_cyc = cyc;
    send(8'hA5, 1'b1, 160.0, 1'b0);
    check("a5_latency", rise_cyc - fall_cyc, 155);
    check("a5_data", bus_a.data, 8'hA5);
    check("a5_valid", bus_a.valid, 1'b1);
    check("a5_rts", bus_a.rts, 1'b0);
    ack_a();
    check("a5_ack_valid", bus_a.valid, 1'b0);
    check("a5_ack_rts", bus_a.rts, 1'b1);

    // 3. Short glitch is rejected as a false start
    f0 = ferr_cnt;
    align();
    rxd_a = 1'b0;
    #40;
    rxd_a = 1'b1;
    repeat (30) align();
    check("glitch_valid", bus_a.valid, 1'b0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    align();
    send(8'h3C, 1'b1, 160.0, 1'b0);
    check("3c_data", bus_a.data, 8'h3C);
    check("3c_valid", bus_a.valid, 1'b1);
    ack_a();

    // 4. Bad stop bit followed by a held-low line
    f0 = ferr_cnt;
    align();
    send(8'h3C, 1'b0, 160.0, 1'b0);
    #400;
    rxd_a = 1'b1;
    repeat (30) align();
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_valid", bus_a.valid, 1'b0);
    align();
    send(8'h81, 1'b1, 160.0, 1'b0);
    check("81_data", bus_a.data, 8'h81);
    check("81_valid", bus_a.valid, 1'b1);
    ack_a();

    // 5. Overrun without ack, then ack coinciding with delivery
    o0 = ovf_cnt;
    align();
    send(8'h11, 1'b1, 160.0, 1'b0);
    check("ovf_first", bus_a.data, 8'h11);
    align();
    send(8'h22, 1'b1, 160.0, 1'b0);
    check("ovf_data", bus_a.data, 8'h11);
    check("ovf_valid", bus_a.valid, 1'b1);
    check("ovf_pulse", ovf_cnt - o0, 1);
    ack_a();
    check("ovf_ack_valid", bus_a.valid, 1'b0);
    align();
    send(8'h11, 1'b1, 160.0, 1'b0);
    o0 = ovf_cnt;
    align();
    fork
      send(8'h22, 1'b1, 160.0, 1'b0);
      begin
        repeat (154) @(posedge clk);
        #1 bus_a.ack = 1'b1;
        @(posedge clk);
        #1 bus_a.ack = 1'b0;
      end
    join
    check("simack_data", bus_a.data, 8'h22);
    check("simack_valid", bus_a.valid, 1'b1);
    check("simack_ovf", ovf_cnt - o0, 0);

    // 6. Reset after bit 3 of 0xFF abandons the frame
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    align();
    rxd_a = 1'b0;
    #160;
    rxd_a = 1'b1;
    #640;
    align();
    rst = 1'b1;
    align();
    rst = 1'b0;
    check("midrst_valid", bus_a.valid, 1'b0);
    check("midrst_data", bus_a.data, 8'h00);
    repeat (200) align();
    check("midrst_idle_valid", bus_a.valid, 1'b0);
    check("midrst_flags", (ferr_cnt - f0) + (ovf_cnt - o0), 0);
    align();
    send(8'h5A, 1'b1, 170.0, 1'b1);
    check("b17_data", bus_b.data, 8'h5A);
    check("b17_valid", bus_b.valid, 1'b1);
    align();
    send(8'h5A, 1'b1, 160.0 / 1.03, 1'b0);
    check("fast3_data", bus_a.data, 8'h5A);
    check("fast3_valid", bus_a.valid, 1'b1);
    check("flags_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
